// File: rtl/sn_pkg.sv
// Shared constants and helpers for the SN76489-style command decoder.
package sn_pkg;

    // Register index = {channel[1:0], type}; type 1 selects attenuation.
    localparam logic [2:0] REG_TONE0 = 3'b000;
    localparam logic [2:0] REG_VOL0  = 3'b001;
    localparam logic [2:0] REG_TONE1 = 3'b010;
    localparam logic [2:0] REG_VOL1  = 3'b011;
    localparam logic [2:0] REG_TONE2 = 3'b100;
    localparam logic [2:0] REG_VOL2  = 3'b101;
    localparam logic [2:0] REG_NOISE = 3'b110;
    localparam logic [2:0] REG_VOL3  = 3'b111;

    localparam logic [3:0] VOL_SILENT = 4'hF;

    localparam int LATCH_BIT = 7;
    localparam int TYPE_BIT  = 4;
    localparam int TONE_W    = 10;

    // Merge a command byte into a tone divider: a latch byte replaces the
    // low nibble, a data byte replaces the upper six bits.
    function automatic logic [TONE_W-1:0] tone_update(
        input logic [TONE_W-1:0] cur,
        input logic [7:0]        cmd
    );
        logic [TONE_W-1:0] res;
        if (cmd[LATCH_BIT]) begin
            res = {cur[TONE_W-1:4], cmd[3:0]};
        end else begin
            res = {cmd[5:0], cur[3:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/sn_cmd_decoder_if.sv
// Byte-stream input and decoded register-file outputs of the command decoder.
interface sn_cmd_decoder_if;
    import sn_pkg::*;

    logic [7:0]        data_in;
    logic              new_data_in;
    logic [TONE_W-1:0] tone0;
    logic [TONE_W-1:0] tone1;
    logic [TONE_W-1:0] tone2;
    logic [3:0]        vol0;
    logic [3:0]        vol1;
    logic [3:0]        vol2;
    logic [3:0]        vol3;
    logic [2:0]        noise_ctrl;
    logic              noise_reset;
    logic              reg_wr;
    logic [2:0]        reg_addr;

    // Decoder side.
    modport slave (
        input  data_in, new_data_in,
        output tone0, tone1, tone2, vol0, vol1, vol2, vol3,
               noise_ctrl, noise_reset, reg_wr, reg_addr
    );

    // Receiver / sound-core side.
    modport master (
        output data_in, new_data_in,
        input  tone0, tone1, tone2, vol0, vol1, vol2, vol3,
               noise_ctrl, noise_reset, reg_wr, reg_addr
    );

endinterface

// File: rtl/edge_sync.sv
// Level synchroniser for an asynchronous input followed by a rising-edge
// detector. All flops reset to 1 so an input idling high never looks like
// a fresh edge when reset is released.
module edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              hist_q;
    logic              hist_d;

    // Shift the input through the synchroniser; history trails the last stage.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_i};
        hist_d = sync_q[STAGES-1];
    end

    // Synchroniser and history flops, preset to the idle-high level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{1'b1}};
            hist_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/sn_cmd_decoder.sv
// Decodes SN76489 command bytes from the serial receiver into the tone,
// attenuation and noise registers of the sound core.
module sn_cmd_decoder
    import sn_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [3:0] VOL_RESET   = VOL_SILENT
) (
    input  logic           clk,
    input  logic           rst_n,
    sn_cmd_decoder_if.slave bus
);

    logic [1:0]                   rst_sync_q;
    logic [1:0]                   rst_sync_d;
    logic                         rst_int_n;
    logic                         byte_stb;

    logic [2:0][TONE_W-1:0]       tone_q;
    logic [2:0][TONE_W-1:0]       tone_d;
    logic [3:0][3:0]              vol_q;
    logic [3:0][3:0]              vol_d;
    logic [2:0]                   noise_ctrl_q;
    logic [2:0]                   noise_ctrl_d;
    logic                         noise_reset_q;
    logic                         noise_reset_d;
    logic                         reg_wr_q;
    logic                         reg_wr_d;
    logic [2:0]                   reg_addr_q;
    logic [2:0]                   reg_addr_d;
    logic [2:0]                   latch_idx_q;
    logic [2:0]                   latch_idx_d;
    logic [2:0]                   idx_s;

    // Reset release is re-timed to clk; assertion stays asynchronous.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    // Reset synchroniser flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_int_n = rst_sync_q[1];

    edge_sync #(
        .STAGES (SYNC_STAGES)
    ) u_new_data_sync (
        .clk     (clk),
        .rst_n   (rst_int_n),
        .async_i (bus.new_data_in),
        .rise_o  (byte_stb)
    );

    // Decode the byte on each strobe and update the register file.
    always_comb begin
        tone_d        = tone_q;
        vol_d         = vol_q;
        noise_ctrl_d  = noise_ctrl_q;
        noise_reset_d = 1'b0;
        reg_wr_d      = 1'b0;
        reg_addr_d    = reg_addr_q;
        latch_idx_d   = latch_idx_q;
        idx_s         = latch_idx_q;

        if (byte_stb) begin
            if (bus.data_in[LATCH_BIT]) begin
                idx_s       = {bus.data_in[6:5], bus.data_in[TYPE_BIT]};
                latch_idx_d = idx_s;
            end else begin
                idx_s = latch_idx_q;
            end

            reg_wr_d   = 1'b1;
            reg_addr_d = idx_s;

            case (idx_s)
                REG_TONE0, REG_TONE1, REG_TONE2: begin
                    tone_d[idx_s[2:1]] = tone_update(tone_q[idx_s[2:1]], bus.data_in);
                end
                REG_VOL0, REG_VOL1, REG_VOL2, REG_VOL3: begin
                    vol_d[idx_s[2:1]] = bus.data_in[3:0];
                end
                REG_NOISE: begin
                    noise_ctrl_d  = bus.data_in[2:0];
                    noise_reset_d = 1'b1;
                end
                default: begin
                    reg_wr_d = 1'b0;
                end
            endcase
        end else begin
            idx_s = latch_idx_q;
        end
    end

    // Register file, latched index and write strobes.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            tone_q        <= '0;
            vol_q         <= {4{VOL_RESET}};
            noise_ctrl_q  <= 3'b000;
            noise_reset_q <= 1'b0;
            reg_wr_q      <= 1'b0;
            reg_addr_q    <= 3'b000;
            latch_idx_q   <= 3'b000;
        end else begin
            tone_q        <= tone_d;
            vol_q         <= vol_d;
            noise_ctrl_q  <= noise_ctrl_d;
            noise_reset_q <= noise_reset_d;
            reg_wr_q      <= reg_wr_d;
            reg_addr_q    <= reg_addr_d;
            latch_idx_q   <= latch_idx_d;
        end
    end

    assign bus.tone0       = tone_q[0];
    assign bus.tone1       = tone_q[1];
    assign bus.tone2       = tone_q[2];
    assign bus.vol0        = vol_q[0];
    assign bus.vol1        = vol_q[1];
    assign bus.vol2        = vol_q[2];
    assign bus.vol3        = vol_q[3];
    assign bus.noise_ctrl  = noise_ctrl_q;
    assign bus.noise_reset = noise_reset_q;
    assign bus.reg_wr      = reg_wr_q;
    assign bus.reg_addr    = reg_addr_q;

endmodule

// File: doc/sn_cmd_decoder.md
Name: sn_cmd_decoder

Overview:
Consumes the byte stream from the serial receiver and decodes SN76489-format command bytes into the sound core's register file. It provides three 10-bit tone dividers, four 4-bit attenuators and the 3-bit noise control, plus a write strobe. It sits between the UART receiver (data_in/new_data_in) and the tone/noise generators.

Parameters:
SYNC_STAGES, 2, flops in the new_data_in synchroniser (min 2)
VOL_RESET, 4'hF, attenuator reset value (F = silent)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
data_in  in  8  received byte; stable while new_data_in high
new_data_in  in  1  receiver idle/byte-complete level; rising edge = new byte
tone0  out  10  channel 0 tone divider
tone1  out  10  channel 1 tone divider
tone2  out  10  channel 2 tone divider
vol0  out  4  channel 0 attenuation
vol1  out  4  channel 1 attenuation
vol2  out  4  channel 2 attenuation
vol3  out  4  noise attenuation
noise_ctrl  out  3  noise control {FB, NF1, NF0}
noise_reset  out  1  one-cycle pulse on every noise_ctrl write
reg_wr  out  1  one-cycle pulse on any register write
reg_addr  out  3  register index written with reg_wr

Behaviour:
- Reset (async, rst_n=0): tone0-2=0, vol0-3=VOL_RESET, noise_ctrl=0, noise_reset=0, reg_wr=0, reg_addr=0, latched index=3'b000, all sync flops=1. Deassertion is synchronised to clk.
- Sync flops reset to 1 because the receiver idles with new_data_in high. Leaving reset therefore never produces a byte.
- Byte strobe: new_data_in passes through SYNC_STAGES flops plus one history flop. byte_stb = synced & ~history.
- If new_data_in rises before edge E0, byte_stb is high between E(SYNC_STAGES-1) and E(SYNC_STAGES). At E(SYNC_STAGES), data_in is sampled, the register is written and reg_wr/reg_addr pulse for exactly one cycle. Default latency is 3 edges.
- new_data_in held high gives one write only. Another write needs a low-then-high transition. Low pulses shorter than one clk are unsupported.
- Register index idx = {cc[1:0], t}: 000 tone0, 001 vol0, 010 tone1, 011 vol1, 100 tone2, 101 vol2, 110 noise, 111 vol3.
- Latch byte (bit7=1): idx=bits6:4, stored as the latched index.
  - Tone: tone[3:0] <= bits3:0; tone[9:4] unchanged.
  - Volume: vol <= bits3:0.
  - Noise: noise_ctrl <= bits2:0; bit3 ignored; noise_reset pulses.
- Data byte (bit7=0): targets the latched index; latched index unchanged.
  - Tone: tone[9:4] <= bits5:0; bit6 ignored.
  - Volume: vol <= bits3:0.
  - Noise: noise_ctrl <= bits2:0 and noise_reset pulses.
- Data byte with no prior latch since reset targets tone0 high bits.
- reg_addr always equals the index actually written.
- noise_reset and reg_wr pulse in the same cycle for noise writes.
- All register outputs are registered, with no combinational path from inputs.
- Reset asserted mid-byte (sync pipeline holding a rising edge): the edge is discarded and no write follows reset release.
- Any byte value is legal; there is no error state.

Decomposition:
- Package sn_pkg:
  - Register index constants REG_TONE0..REG_VOL3 (3-bit).
  - VOL_SILENT=4'hF.
  - Bit positions LATCH_BIT=7, TYPE_BIT=4.
  - Tone width constant TONE_W=10.
- Sub-module edge_sync (parameter STAGES, reset value 1): synchroniser plus rising-edge pulse. Reused for other async level inputs.
- Decode and register file stay in sn_cmd_decoder.

Test Plan:
- Reset release with new_data_in=1 held for 100 cycles -> reg_wr never pulses; tones 0, vols F, noise_ctrl 0.
- Bytes 0xA5 then 0x3C -> tone1=0x3C5. reg_wr pulses twice with reg_addr=2, each 3 edges after the rising edge.
- 0x97 then 0x02 -> vol0=7, then vol0=2 (data byte rewrites latched volume); reg_addr=1 both times.
- 0xE5 -> noise_ctrl=5, noise_reset high exactly 1 cycle; 0x03 follows -> noise_ctrl=3, second noise_reset pulse.
- After reset, data byte 0x15 with no latch -> tone0=0x150, reg_addr=0; 0xD3 -> vol2=3, tone0 unchanged.
- new_data_in rises, rst_n pulsed low 1 cycle later for 2 cycles -> no write after release; outputs at reset values.
